// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl
//   Scan sequencer for a HUB75 1/8-scan LED panel. Each (row, plane) slot is
//   fetched pixel by pixel from a frame-buffer port, shifted out on rgb0/rgb1
//   with sclk, then blanked, latched and shown for a binary-weighted on-time
//   (intensity << plane). The next slot is shifted while the previous one is
//   displayed; the display timer runs on its own and only gates oe_n.
//
//   Scan order: planes inner, rows outer, wrapping after the last row.
//
// Handshake (pixel port): pix_req is held high in FETCH with pix_row/pix_col/
//   pix_plane stable. A request completes in the cycle pix_valid is high; the
//   data on pix_rgb0/pix_rgb1 is captured on that edge and pix_req drops the
//   next cycle. There is no bound on how long pix_valid may take.
//
// Ports
//   clk, rst            system clock, asynchronous active-low reset
//   enable              run scan; sampled in IDLE and at the end of LATCH
//   intensity[6:0]      plane-0 on-time in clk cycles, sampled at timer load
//   pix_req/row/col/plane/valid/rgb0/rgb1  frame-buffer fetch port
//   rgb0, rgb1, sclk, lat, oe_n, addr      panel pins
//   frame_start         1-cycle pulse on LATCH entry for row 0 plane 0
//   busy                high in any state but IDLE
//   dbg_state           current FSM state encoding
module hub75_scan_ctrl #(
  parameter int COLS     = 32,
  parameter int ROW_BITS = 3,
  parameter int PLANES   = 4,
  parameter int CLK_DIV  = 4,
  localparam int COL_BITS = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int PL_BITS  = (PLANES > 1) ? $clog2(PLANES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [6:0]          intensity,
  output logic                pix_req,
  output logic [ROW_BITS-1:0] pix_row,
  output logic [COL_BITS-1:0] pix_col,
  output logic [PL_BITS-1:0]  pix_plane,
  input  logic                pix_valid,
  input  logic [2:0]          pix_rgb0,
  input  logic [2:0]          pix_rgb1,
  output logic [2:0]          rgb0,
  output logic [2:0]          rgb1,
  output logic                sclk,
  output logic                lat,
  output logic                oe_n,
  output logic [ROW_BITS-1:0] addr,
  output logic                frame_start,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  localparam int TMR_W = 7 + PLANES - 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_SHIFT_LO  = 3'd2,
    S_SHIFT_HI  = 3'd3,
    S_WAIT_DISP = 3'd4,
    S_BLANK     = 3'd5,
    S_LATCH     = 3'd6
  } state_t;

  state_t              state, state_n;
  logic [DIV_W-1:0]    div_cnt;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [PL_BITS-1:0]  plane;
  logic [TMR_W-1:0]    timer;

  logic phase_done;
  logic last_col;
  logic last_plane;
  logic latch_exit;

  assign phase_done = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_col   = (col == COL_BITS'(COLS - 1));
  assign last_plane = (plane == PL_BITS'(PLANES - 1));
  assign latch_exit = (state == S_LATCH) && phase_done;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (enable) state_n = S_FETCH;
      S_FETCH:     if (pix_valid) state_n = S_SHIFT_LO;
      S_SHIFT_LO:  if (phase_done) state_n = S_SHIFT_HI;
      S_SHIFT_HI:  if (phase_done) state_n = last_col ? S_WAIT_DISP : S_FETCH;
      S_WAIT_DISP: if (timer == '0) state_n = S_BLANK;
      S_BLANK:     state_n = S_LATCH;
      S_LATCH:     if (phase_done) state_n = enable ? S_FETCH : S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Phase counter for the timed states; restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (state_n != state) begin
      div_cnt <= '0;
    end else if (state == S_SHIFT_LO || state == S_SHIFT_HI || state == S_LATCH) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Column advances at the end of each sclk high phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
    end else if (state == S_SHIFT_HI && phase_done) begin
      col <= last_col ? '0 : col + COL_BITS'(1);
    end
  end

  // Row/plane advance once the slot has been latched. Stopping returns the
  // scan to row 0 plane 0 so a restart begins a fresh frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row   <= '0;
      plane <= '0;
    end else if (latch_exit) begin
      if (!enable) begin
        row   <= '0;
        plane <= '0;
      end else if (last_plane) begin
        plane <= '0;
        row   <= row + ROW_BITS'(1);
      end else begin
        plane <= plane + PL_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb0 <= '0;
      rgb1 <= '0;
    end else if (state == S_FETCH && pix_valid) begin
      rgb0 <= pix_rgb0;
      rgb1 <= pix_rgb1;
    end
  end

  // addr and frame_start update on the edge that enters LATCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr        <= '0;
      frame_start <= 1'b0;
    end else if (state == S_BLANK) begin
      addr        <= row;
      frame_start <= (row == '0) && (plane == '0);
    end else begin
      frame_start <= 1'b0;
    end
  end

  // Display timer: loaded as lat falls with the plane just latched, so the
  // on-time never overlaps lat. WAIT_DISP guarantees it is already zero here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (latch_exit) begin
      timer <= TMR_W'(intensity) << plane;
    end else if (timer != '0) begin
      timer <= timer - TMR_W'(1);
    end
  end

  assign pix_req   = (state == S_FETCH);
  assign pix_row   = row;
  assign pix_col   = col;
  assign pix_plane = plane;
  assign sclk      = (state == S_SHIFT_HI);
  assign lat       = (state == S_LATCH);
  assign oe_n      = (timer == '0);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Testbench for hub75_scan_ctrl (default parameters: 32 cols, 8 rows,
// 4 planes, CLK_DIV 4). A pixel responder tracks the expected scan position,
// serves frame-buffer requests and pushes expected shift data, latch
// address/frame_start and oe_n on-times into queues; monitors pop and compare
// as the panel pins show them.
module tb_hub75_scan_ctrl;

  localparam int COLS    = 32;
  localparam int PLANES  = 4;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] intensity = '0;
  logic       pix_req;
  logic [2:0] pix_row;
  logic [4:0] pix_col;
  logic [1:0] pix_plane;
  logic       pix_valid = 1'b0;
  logic [2:0] pix_rgb0 = '0;
  logic [2:0] pix_rgb1 = '0;
  logic [2:0] rgb0, rgb1;
  logic       sclk, lat, oe_n;
  logic [2:0] addr;
  logic       frame_start, busy;
  logic [2:0] dbg_state;

  hub75_scan_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .intensity(intensity),
    .pix_req(pix_req), .pix_row(pix_row), .pix_col(pix_col),
    .pix_plane(pix_plane), .pix_valid(pix_valid), .pix_rgb0(pix_rgb0),
    .pix_rgb1(pix_rgb1), .rgb0(rgb0), .rgb1(rgb1), .sclk(sclk), .lat(lat),
    .oe_n(oe_n), .addr(addr), .frame_start(frame_start), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [5:0] pix_q[$];   // {rgb1, rgb0}
  logic [3:0] lat_q[$];   // {addr, frame_start}
  logic [9:0] oe_q[$];    // expected oe_n low run length

  int m_row = 0, m_col = 0, m_plane = 0;
  int stall_row = -1, stall_col = -1, stall_plane = -1, stall_len = 0;
  bit chk_en = 1'b1;
  int lat_cnt = 0;
  int fs_stray = 0;
  int ov_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] pix_fn(input int r, input int c, input int p);
    logic [2:0] a, b;
    a = 3'(c + 2 * r + 5 * p);
    b = 3'((c ^ (r * 3)) + p);
    return {b, a};
  endfunction

  // ---------------- pixel responder (driver + expected model) ----------------
  initial begin
    logic [5:0] data;
    bit ok;
    forever begin
      @(negedge clk);
      if (pix_req && chk_en) begin
        check("req_row", pix_row, m_row);
        check("req_col", pix_col, m_col);
        check("req_plane", pix_plane, m_plane);
        if (m_row == stall_row && m_col == stall_col && m_plane == stall_plane) begin
          ok = 1'b1;
          for (int i = 0; i < stall_len; i++) begin
            @(negedge clk);
            if (!(pix_req && !sclk && pix_row == 3'(m_row) && pix_col == 5'(m_col) &&
                  pix_plane == 2'(m_plane))) ok = 1'b0;
          end
          check("stall_hold", ok, 1);
          stall_row = -1;
        end
        data = pix_fn(m_row, m_col, m_plane);
        {pix_rgb1, pix_rgb0} = data;
        pix_valid = 1'b1;
        pix_q.push_back(data);
        @(negedge clk);
        pix_valid = 1'b0;
        check("req_drop", pix_req, 0);
        if (m_col == COLS - 1) begin
          m_col = 0;
          lat_q.push_back({3'(m_row), (m_row == 0 && m_plane == 0)});
          if (intensity != 0) oe_q.push_back(10'(intensity) << m_plane);
          if (!enable) begin
            m_row = 0;
            m_plane = 0;
          end else if (m_plane == PLANES - 1) begin
            m_plane = 0;
            m_row = (m_row + 1) % 8;
          end else begin
            m_plane++;
          end
        end else begin
          m_col++;
        end
      end
    end
  end

  // ---------------- monitor: shift data and sclk timing ----------------
  initial begin
    logic sclk_p;
    logic [5:0] rgb_p, e;
    int hi_w, stable;
    sclk_p = 1'b0; rgb_p = '0; hi_w = 0; stable = 0;
    forever begin
      @(negedge clk);
      if ({rgb1, rgb0} != rgb_p) stable = 0; else stable++;
      rgb_p = {rgb1, rgb0};
      if (chk_en) begin
        if (sclk && !sclk_p) begin
          check("setup_cycles", stable >= CLK_DIV, 1);
          if (pix_q.size() == 0) check("rgb_unexpected", 1, 0);
          else begin
            e = pix_q.pop_front();
            check("rgb", {rgb1, rgb0}, e);
          end
          hi_w = 0;
        end
        if (sclk) hi_w++;
        if (!sclk && sclk_p) check("sclk_high_width", hi_w, CLK_DIV);
      end
      sclk_p = sclk;
    end
  end

  // ---------------- monitor: latch, addr, frame_start ----------------
  initial begin
    logic lat_p;
    logic [3:0] e;
    int lw;
    lat_p = 1'b0; lw = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (lat && !lat_p) begin
          lat_cnt++;
          check("lat_oe_n", oe_n, 1);
          if (lat_q.size() == 0) check("lat_unexpected", 1, 0);
          else begin
            e = lat_q.pop_front();
            check("lat_addr", addr, e[3:1]);
            check("frame_start", frame_start, e[0]);
          end
          lw = 0;
        end else if (frame_start) begin
          fs_stray++;
        end
        if (lat) begin
          lw++;
          if (!oe_n) ov_cnt++;
        end
        if (!lat && lat_p) check("lat_width", lw, CLK_DIV);
      end
      lat_p = lat;
    end
  end

  // ---------------- monitor: oe_n on-time ----------------
  initial begin
    int run;
    logic [9:0] e;
    run = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (!oe_n) run++;
        else if (run > 0) begin
          if (oe_q.size() == 0) check("oe_unexpected", run, 0);
          else begin
            e = oe_q.pop_front();
            check("oe_low_cycles", run, e);
          end
          run = 0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_lat(input int n, input int budget, input string nm);
    int c = 0;
    while (lat_cnt < n && c < budget) begin @(negedge clk); c++; end
    check(nm, lat_cnt >= n, 1);
  endtask

  task automatic wait_req(input int budget, input string nm);
    int c = 0;
    while (!pix_req && c < budget) begin @(negedge clk); c++; end
    check(nm, pix_req, 1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int c = 0;
    while (busy && c < budget) begin @(negedge clk); c++; end
    check(nm, busy, 0);
  endtask

  task automatic stop_and_drain(input string nm);
    wait_req(200, {nm, "_req"});
    enable = 1'b0;
    wait_idle(1000, {nm, "_idle"});
    repeat (100) @(negedge clk);
    check({nm, "_oe_n"}, oe_n, 1);
    check({nm, "_pix_q"}, pix_q.size(), 0);
    check({nm, "_lat_q"}, lat_q.size(), 0);
    check({nm, "_oe_q"}, oe_q.size(), 0);
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_oe_n"}, oe_n, 1);
    check({nm, "_lat"}, lat, 0);
    check({nm, "_sclk"}, sclk, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_pix_req"}, pix_req, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    // Reset with enable low: outputs at rest and held there.
    repeat (3) @(negedge clk);
    check_quiet("rst");
    check("rst_addr", addr, 0);
    check("rst_rgb", {rgb1, rgb0}, 0);
    check("rst_fs", frame_start, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_quiet("held");

    // Intensity 10 over a full frame plus one slot; stall at col 5 of r0 p0.
    intensity = 7'd10;
    stall_row = 0; stall_col = 5; stall_plane = 0; stall_len = 50;
    enable = 1'b1;
    wait_lat(33, 20000, "frame_a");
    stop_and_drain("stop_a");

    // Intensity 0: panel stays dark, frame_start on latch 1 and 33.
    base = lat_cnt;
    intensity = 7'd0;
    enable = 1'b1;
    wait_lat(base + 33, 20000, "frame_b");
    stop_and_drain("stop_b");

    // Drop enable mid-shift of row 3: row 3 is latched and displayed, then idle.
    intensity = 7'd3;
    enable = 1'b1;
    begin
      int c = 0;
      while (!(m_row == 3 && m_col == 10) && c < 8000) begin @(negedge clk); c++; end
      check("reach_row3", (m_row == 3 && m_col == 10), 1);
    end
    enable = 1'b0;
    wait_idle(1000, "stop_c_idle");
    check("stop_c_addr", addr, 3);
    repeat (20) @(negedge clk);
    check_quiet("stop_c");
    check("stop_c_oe_q", oe_q.size(), 0);
    check("stop_c_lat_q", lat_q.size(), 0);

    // Restart from row 0 plane 0, then async reset in the middle of display.
    base = lat_cnt;
    intensity = 7'd100;
    enable = 1'b1;
    wait_lat(base + 1, 1000, "restart_lat");
    begin
      int c = 0;
      while (oe_n && c < 100) begin @(negedge clk); c++; end
      check("restart_oe_low", oe_n, 0);
    end
    repeat (5) @(negedge clk);
    check("fs_stray", fs_stray, 0);
    check("lat_oe_overlap", ov_cnt, 0);
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_quiet("async_rst");
    check("async_rst_addr", addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
